msgdma_desc_arbiter: RTL and testbench

MSGDMA_DESC_ARBITER -- requirements
Module: msgdma_desc_arbiter

---
 rtl/msgdma_desc_pkg.sv | 32 +++
 rtl/desc_id_fifo.sv | 60 ++++++
 rtl/msgdma_desc_arbiter.sv | 158 +++++++++++++++
 tb/tb_msgdma_desc_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msgdma_desc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msgdma_desc_pkg
//  Purpose  : Shared states and descriptor-word constants for the mSGDMA
//             descriptor arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package msgdma_desc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_RADDR = 3'd1,
      ST_WR_WADDR = 3'd2,
      ST_WR_LEN   = 3'd3,
      ST_WR_CTRL  = 3'd4
   } state_t;

   localparam logic [1:0] c_WORD_RADDR = 2'd0;
   localparam logic [1:0] c_WORD_WADDR = 2'd1;
   localparam logic [1:0] c_WORD_LEN   = 2'd2;
   localparam logic [1:0] c_WORD_CTRL  = 2'd3;

   localparam int c_GO_BIT  = 31;
   localparam int c_SOP_BIT = 8;
   localparam int c_EOP_BIT = 9;

   localparam logic [31:0] c_CTRL_WORD = (32'd1 << c_GO_BIT)
                                       | (32'd1 << c_SOP_BIT)
                                       | (32'd1 << c_EOP_BIT);

endpackage
`default_nettype wire

// File: rtl/desc_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : desc_id_fifo
//  Purpose  : In-flight requester-ID FIFO, 1-bit wide, simultaneous push/pop.
//  Revision : 1.0  initial release
// ============================================================================
module desc_id_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_push_data,
   input  logic                     i_pop,
   output logic                     o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   c_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] c_ONE  = PTR_W'(1);

   logic [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_pop;
   logic             w_do_push;

   // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + c_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/msgdma_desc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : msgdma_desc_arbiter
//  Purpose  : Round-robin arbiter for two requesters that writes 4-word
//             descriptors to an mSGDMA dispatcher and tracks completions.
//  Revision : 1.0  initial release
// ============================================================================
module msgdma_desc_arbiter
   import msgdma_desc_pkg::*;
#(
   parameter int MAX_OUT = 8,
   parameter int ADDR_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [2*ADDR_W-1:0]       req_addr,
   input  logic [63:0]               req_len,
   output logic [1:0]                avm_address,
   output logic                      avm_write,
   output logic [31:0]               avm_writedata,
   input  logic                      avm_waitrequest,
   input  logic                      st_valid,
   input  logic                      st_ready,
   input  logic                      st_eop,
   output logic [1:0]                done,
   output logic [$clog2(MAX_OUT):0]  outstanding,
   output logic                      err_orphan_eop
);

   localparam int CNT_W = $clog2(MAX_OUT) + 1;
   localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_OUT);

   state_t            r_state;
   logic              r_avm_write;
   logic [1:0]        r_avm_addr;
   logic [31:0]       r_avm_data;
   logic [31:0]       r_len;
   logic              r_id;
   logic              r_prio;
   logic [1:0]        r_done;
   logic              r_orphan;

   logic              w_eop;
   logic              w_pop;
   logic              w_push;
   logic              w_grant;
   logic              w_winner;
   logic              w_head;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [31:0]       w_sel_len;
   logic [CNT_W-1:0]  w_count;

   assign w_eop  = st_valid && st_ready && st_eop;
   assign w_pop  = w_eop && (w_count != '0);
   assign w_push = (r_state == ST_WR_CTRL) && !avm_waitrequest;

   // A pop in the grant cycle frees a slot, so a full arbiter can grant immediately.
   assign w_grant    = reset_n && (r_state == ST_IDLE) && (req_valid != 2'b00)
                       && ((w_count < c_MAX_CNT) || w_pop);
   assign w_winner   = (req_valid == 2'b11) ? r_prio : req_valid[1];
   assign w_sel_addr = w_winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
   assign w_sel_len  = w_winner ? req_len[63:32] : req_len[31:0];
   assign req_ready  = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_avm_write <= 1'b0;
         r_avm_addr  <= c_WORD_RADDR;
         r_avm_data  <= 32'd0;
         r_len       <= 32'd0;
         r_id        <= 1'b0;
         r_prio      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_state     <= ST_WR_RADDR;
                  r_avm_write <= 1'b1;
                  r_avm_addr  <= c_WORD_RADDR;
                  r_avm_data  <= 32'(w_sel_addr);
                  r_len       <= w_sel_len;
                  r_id        <= w_winner;
                  r_prio      <= ~w_winner;
               end
            end
            ST_WR_RADDR: begin
               if (!avm_waitrequest) begin
                  r_state    <= ST_WR_WADDR;
                  r_avm_addr <= c_WORD_WADDR;
                  r_avm_data <= 32'd0;
               end
            end
            ST_WR_WADDR: begin
               if (!avm_waitrequest) begin
                  r_state    <= ST_WR_LEN;
                  r_avm_addr <= c_WORD_LEN;
                  r_avm_data <= r_len;
               end
            end
            ST_WR_LEN: begin
               if (!avm_waitrequest) begin
                  r_state    <= ST_WR_CTRL;
                  r_avm_addr <= c_WORD_CTRL;
                  r_avm_data <= c_CTRL_WORD;
               end
            end
            ST_WR_CTRL: begin
               if (!avm_waitrequest) begin
                  r_state     <= ST_IDLE;
                  r_avm_write <= 1'b0;
                  r_avm_addr  <= c_WORD_RADDR;
                  r_avm_data  <= 32'd0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_avm_write <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done   <= 2'b00;
         r_orphan <= 1'b0;
      end else begin
         r_done <= w_pop ? (w_head ? 2'b10 : 2'b01) : 2'b00;
         if (w_eop && (w_count == '0)) begin
            r_orphan <= 1'b1;
         end
      end
   end

   desc_id_fifo #(
      .DEPTH (MAX_OUT)
   ) u_id_fifo (
      .clk         (clk),
      .rst_n       (reset_n),
      .i_push      (w_push),
      .i_push_data (r_id),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count)
   );

   assign avm_write      = r_avm_write;
   assign avm_address    = r_avm_addr;
   assign avm_writedata  = r_avm_data;
   assign done           = r_done;
   assign outstanding    = w_count;
   assign err_orphan_eop = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_msgdma_desc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msgdma_desc_arbiter
//  Purpose  : Directed and random bench for msgdma_desc_arbiter with a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_msgdma_desc_arbiter;

   localparam int MAX_OUT = 8;
   localparam int ADDR_W  = 32;
   localparam int CNT_W   = $clog2(MAX_OUT) + 1;
   localparam logic [31:0] c_CTRL = 32'h8000_0300;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [63:0]      req_addr;
   logic [63:0]      req_len;
   logic [1:0]       avm_address;
   logic             avm_write;
   logic [31:0]      avm_writedata;
   logic             avm_waitrequest;
   logic             st_valid, st_ready, st_eop;
   logic [1:0]       done;
   logic [CNT_W-1:0] outstanding;
   logic             err_orphan_eop;

   int n_assert = 0;
   int n_fail   = 0;

   msgdma_desc_arbiter #(.MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .req_len         (req_len),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .st_valid        (st_valid),
      .st_ready        (st_ready),
      .st_eop          (st_eop),
      .done            (done),
      .outstanding     (outstanding),
      .err_orphan_eop  (err_orphan_eop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh(input int i);
      return (i != 0) ? 2'b10 : 2'b01;
   endfunction

   // Reference model: expected bus words, granted/committed IDs, count.
   logic [33:0] exp_q[$];
   bit          id_pend[$];
   bit          id_q[$];
   int          m_cnt = 0;
   bit          m_prio = 1'b0;
   bit          m_orphan = 1'b0;
   logic [1:0]  m_done_nx = 2'b00;
   bit          stall_prev = 1'b0;
   logic [1:0]  addr_prev;
   logic [31:0] data_prev;

   always @(negedge clk) begin
      bit          win, evt_eop, allow, commit, head;
      logic [33:0] e;
      if (!reset_n) begin
         exp_q.delete(); id_pend.delete(); id_q.delete();
         m_cnt = 0; m_prio = 1'b0; m_orphan = 1'b0; m_done_nx = 2'b00;
         stall_prev = 1'b0;
      end else begin
         chk("mon_done", 64'(done), 64'(m_done_nx));
         chk("mon_outstanding", 64'(outstanding), 64'(m_cnt));
         chk("mon_orphan", 64'(err_orphan_eop), 64'(m_orphan));
         evt_eop = st_valid && st_ready && st_eop;
         allow   = (m_cnt < MAX_OUT) || (evt_eop && m_cnt > 0);
         if (!allow) chk("mon_full_block", 64'(req_ready), 64'(0));
         if (req_ready != 2'b00) begin
            win = (req_valid == 2'b11) ? m_prio : req_valid[1];
            chk("mon_grant_winner", 64'(req_ready), 64'(oh(int'(win))));
            exp_q.push_back({2'd0, win ? req_addr[63:32] : req_addr[31:0]});
            exp_q.push_back({2'd1, 32'd0});
            exp_q.push_back({2'd2, win ? req_len[63:32] : req_len[31:0]});
            exp_q.push_back({2'd3, c_CTRL});
            id_pend.push_back(win);
            m_prio = !win;
         end
         if (stall_prev && avm_write) begin
            chk("mon_hold_addr", 64'(avm_address), 64'(addr_prev));
            chk("mon_hold_data", 64'(avm_writedata), 64'(data_prev));
         end
         stall_prev = avm_write && avm_waitrequest;
         addr_prev  = avm_address;
         data_prev  = avm_writedata;
         commit = 1'b0;
         if (avm_write && !avm_waitrequest) begin
            chk("mon_bus_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("mon_bus_addr", 64'(avm_address), 64'(e[33:32]));
               chk("mon_bus_data", 64'(avm_writedata), 64'(e[31:0]));
               commit = (e[33:32] == 2'd3);
            end
         end
         m_done_nx = 2'b00;
         if (evt_eop) begin
            if (m_cnt > 0) begin
               head = id_q.pop_front();
               m_done_nx = oh(int'(head));
               m_cnt--;
            end else begin
               m_orphan = 1'b1;
            end
         end
         if (commit && id_pend.size() != 0) begin
            id_q.push_back(id_pend.pop_front());
            m_cnt++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic pulse_eop();
      st_valid = 1'b1; st_ready = 1'b1; st_eop = 1'b1;
      cyc();
      st_valid = 1'b0; st_ready = 1'b0; st_eop = 1'b0;
   endtask

   task automatic wait_out(input int target, input int budget, input string tag);
      for (int c = 0; c < budget && outstanding != CNT_W'(target); c++) cyc();
      chk(tag, 64'(outstanding), 64'(target));
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_avm_write"}, 64'(avm_write), 64'(0));
      chk({tag, "_avm_address"}, 64'(avm_address), 64'(0));
      chk({tag, "_avm_writedata"}, 64'(avm_writedata), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_outstanding"}, 64'(outstanding), 64'(0));
      chk({tag, "_orphan"}, 64'(err_orphan_eop), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t1w [4];
      logic [1:0]  gseq [4];
      int          grants;
      bit          got;
      int          k;
      logic [31:0] blen;

      t1w = '{32'h1000_0000, 32'd0, 32'd256, c_CTRL};
      req_valid = 2'b00; req_addr = '0; req_len = '0; avm_waitrequest = 1'b0;
      st_valid = 1'b0; st_ready = 1'b0; st_eop = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) cyc();
      check_idle_outputs("reset");
      reset_n = 1'b1;
      cyc();

      // Single request: four consecutive words, then one completion.
      req_addr[31:0] = 32'h1000_0000; req_len[31:0] = 32'd256; req_valid = 2'b01;
      #1 chk("t1_ready", 64'(req_ready), 64'(2'b01));
      cyc();
      req_valid = 2'b00;
      for (int i = 0; i < 4; i++) begin
         chk("t1_write", 64'(avm_write), 64'(1));
         chk("t1_addr", 64'(avm_address), 64'(i));
         chk("t1_data", 64'(avm_writedata), 64'(t1w[i]));
         cyc();
      end
      chk("t1_write_end", 64'(avm_write), 64'(0));
      chk("t1_outstanding", 64'(outstanding), 64'(1));
      pulse_eop();
      chk("t1_done", 64'(done), 64'(2'b01));
      chk("t1_out_zero", 64'(outstanding), 64'(0));
      cyc();
      chk("t1_done_clear", 64'(done), 64'(0));

      // Contention: both requesters continuously valid.
      do_reset();
      req_addr = {$urandom, $urandom}; req_len = {$urandom, $urandom}; req_valid = 2'b11;
      grants = 0;
      for (int c = 0; c < 200 && grants < 4; c++) begin
         avm_waitrequest = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         got = (req_ready != 2'b00);
         if (got) begin gseq[grants] = req_ready; grants++; end
         cyc();
         if (got) begin
            if (gseq[grants-1][1]) begin req_addr[63:32] = $urandom; req_len[63:32] = $urandom; end
            else begin req_addr[31:0] = $urandom; req_len[31:0] = $urandom; end
         end
      end
      req_valid = 2'b00; avm_waitrequest = 1'b0;
      chk("rr_grants", 64'(grants), 64'(4));
      for (int i = 0; i < 4; i++) chk("rr_order", 64'(gseq[i]), 64'(oh(i % 2)));
      wait_out(4, 40, "rr_commit");
      for (int i = 0; i < 4; i++) begin
         pulse_eop();
         chk("rr_done", 64'(done), 64'(oh(i % 2)));
         cyc();
      end

      // Backpressure on the length word, requester 1.
      blen = $urandom;
      req_addr[63:32] = $urandom; req_len[63:32] = blen; req_valid = 2'b10;
      #1 chk("bp_ready", 64'(req_ready), 64'(2'b10));
      cyc();
      req_valid = 2'b00;
      chk("bp_w0", 64'(avm_address), 64'(0));
      cyc();
      chk("bp_w1", 64'(avm_address), 64'(1));
      cyc();
      for (int i = 0; i < 4; i++) begin
         avm_waitrequest = (i < 3);
         chk("bp_hold_addr", 64'(avm_address), 64'(2));
         chk("bp_hold_data", 64'(avm_writedata), 64'(blen));
         chk("bp_hold_write", 64'(avm_write), 64'(1));
         cyc();
      end
      avm_waitrequest = 1'b0;
      chk("bp_w3", 64'(avm_address), 64'(3));
      chk("bp_ctrl", 64'(avm_writedata), 64'(c_CTRL));
      cyc();
      pulse_eop();
      chk("bp_done", 64'(done), 64'(2'b10));

      // Full: eight descriptors in flight, then regrant in the pop cycle.
      req_addr[31:0] = $urandom; req_len[31:0] = 32'd0; req_valid = 2'b01;
      grants = 0;
      for (int c = 0; c < 200 && grants < 8; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) grants++;
         cyc();
      end
      chk("full_grants", 64'(grants), 64'(8));
      wait_out(8, 20, "full_commit");
      for (int i = 0; i < 6; i++) begin
         chk("full_ready_low", 64'(req_ready), 64'(0));
         cyc();
      end
      st_valid = 1'b1; st_ready = 1'b1; st_eop = 1'b1;
      #1 chk("full_regrant", 64'(req_ready), 64'(2'b01));
      cyc();
      st_valid = 1'b0; st_ready = 1'b0; st_eop = 1'b0; req_valid = 2'b00;
      chk("full_pop", 64'(outstanding), 64'(7));
      wait_out(8, 20, "full_refill");
      for (int i = 0; i < 8; i++) begin
         pulse_eop();
         k = $urandom_range(0, 2);
         repeat (k) cyc();
      end
      chk("full_drained", 64'(outstanding), 64'(0));

      // Orphan completion.
      cyc();
      pulse_eop();
      chk("orph_flag", 64'(err_orphan_eop), 64'(1));
      chk("orph_done", 64'(done), 64'(0));
      chk("orph_out", 64'(outstanding), 64'(0));
      cyc();
      chk("orph_sticky", 64'(err_orphan_eop), 64'(1));

      // Asynchronous reset while writing word 1.
      do_reset();
      req_addr[31:0] = $urandom; req_len[31:0] = $urandom; req_valid = 2'b01;
      cyc();
      req_valid = 2'b00;
      cyc();
      chk("rst_in_waddr", 64'(avm_address), 64'(1));
      #1 reset_n = 1'b0;
      #1 check_idle_outputs("async_reset");
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
      k = $urandom_range(0, 1);
      req_addr = {$urandom, $urandom}; req_len = {$urandom, $urandom}; req_valid = oh(k);
      #1 chk("fresh_ready", 64'(req_ready), 64'(oh(k)));
      cyc();
      req_valid = 2'b00;
      wait_out(1, 20, "fresh_commit");
      pulse_eop();
      chk("fresh_done", 64'(done), 64'(oh(k)));

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         req_valid = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            req_addr = {$urandom, $urandom};
            req_len[31:0]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            req_len[63:32] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         end
         avm_waitrequest = ($urandom_range(0, 3) == 0);
         st_valid = 1'($urandom_range(0, 1));
         st_ready = 1'($urandom_range(0, 1));
         st_eop   = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
         cyc();
      end
      req_valid = 2'b00; avm_waitrequest = 1'b0;
      st_valid = 1'b0; st_ready = 1'b0; st_eop = 1'b0;
      repeat (12) cyc();
      for (int c = 0; c < 20 && m_cnt > 0; c++) pulse_eop();
      chk("final_drain", 64'(outstanding), 64'(0));
      cyc();
      chk("final_orphan", 64'(err_orphan_eop), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
